// File: rtl/tty_fb_pkg.sv
// Shared constants and state encoding for the glass-TTY framebuffer writer.
package tty_fb_pkg;

  localparam int          WORDS_PER_ROW = 16;
  localparam logic [7:0]  SPACE         = 8'h20;
  localparam logic [63:0] SPACE_WORD    = {8{SPACE}};

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCR_RD,
    SCR_WT,
    SCR_WR,
    CLR
  } tty_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/tty_fb_writer.sv
// Glass-TTY writer: turns a byte stream into character writes on the 64-bit
// CPU-side port of the text framebuffer, with cursor handling, scroll-up by
// row copy and screen clear. Every port-B output is a register.
module tty_fb_writer
  import tty_fb_pkg::*;
#(
  parameter int COLS           = 128,
  parameter int ROWS           = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk_data,
  input  logic        rst_ni,
  input  logic [7:0]  tty_data,
  input  logic        tty_valid,
  output logic        tty_ready,
  output logic        enb,
  output logic [7:0]  web,
  output logic [10:0] addrb,
  output logic [63:0] dinb,
  input  logic [63:0] doutb,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  // Word-address landmarks for the copy and clear loops.
  localparam logic [10:0] ROW_STRIDE  = 11'(WORDS_PER_ROW);
  localparam logic [10:0] LAST_COPY_W = 11'((ROWS - 1) * WORDS_PER_ROW - 1);
  localparam logic [10:0] LAST_ROW_W0 = 11'((ROWS - 1) * WORDS_PER_ROW);
  localparam logic [10:0] LAST_W_ALL  = 11'(ROWS * WORDS_PER_ROW - 1);
  localparam logic [5:0]  LAST_ROW    = 6'(ROWS - 1);
  localparam logic [7:0]  COLS_W      = 8'(COLS);

  tty_state_t  state_reg, state_next;
  logic [5:0]  row_reg, row_next;
  logic [6:0]  col_reg, col_next;
  logic [10:0] w_reg, w_next;
  logic [10:0] end_reg, end_next;
  logic        scroll_pend_reg, scroll_pend_next;
  logic        init_pend_reg, init_pend_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic        enb_reg, enb_next;
  logic [7:0]  web_reg, web_next;
  logic [10:0] addrb_reg, addrb_next;
  logic [63:0] dinb_reg, dinb_next;

  logic [7:0]  col_inc;
  logic        accept;

  assign col_inc = {1'b0, col_reg} + 8'd1;
  assign accept  = tty_valid && ready_reg;

  // Next-state, cursor and counter logic, then the port-B values for the
  // cycle spent in the next state (so the outputs can be registered).
  always_comb begin
    state_next       = state_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    w_next           = w_reg;
    end_next         = end_reg;
    scroll_pend_next = scroll_pend_reg;
    init_pend_next   = init_pend_reg;
    enb_next         = 1'b0;
    web_next         = 8'h00;
    addrb_next       = 11'd0;
    dinb_next        = 64'd0;

    case (state_reg)
      IDLE: begin
        if (init_pend_reg) begin
          // First cycle out of reset: optionally wipe the whole screen.
          init_pend_next = 1'b0;
          if (CLEAR_ON_RESET != 0) begin
            state_next = CLR;
            w_next     = 11'd0;
            end_next   = LAST_W_ALL;
          end
        end else if (accept) begin
          if (is_printable(tty_data)) begin
            state_next       = PUT;
            scroll_pend_next = 1'b0;
            if (col_inc == COLS_W) begin
              col_next = 7'd0;
              if (row_reg < LAST_ROW) row_next = row_reg + 6'd1;
              else                    scroll_pend_next = 1'b1;
            end else begin
              col_next = col_inc[6:0];
            end
          end else begin
            case (tty_data)
              CR: col_next = 7'd0;
              LF: begin
                if (row_reg < LAST_ROW) begin
                  row_next = row_reg + 6'd1;
                end else begin
                  state_next = SCR_RD;
                  w_next     = 11'd0;
                end
              end
              BS: begin
                if (col_reg != 7'd0) col_next = col_reg - 7'd1;
              end
              FF: begin
                state_next = CLR;
                w_next     = 11'd0;
                end_next   = LAST_W_ALL;
                row_next   = 6'd0;
                col_next   = 7'd0;
              end
              default: ;  // unknown byte: handshake consumed, nothing else
            endcase
          end
        end
      end

      PUT: begin
        if (scroll_pend_reg) begin
          state_next       = SCR_RD;
          w_next           = 11'd0;
          scroll_pend_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end

      SCR_RD: state_next = SCR_WT;

      SCR_WT: state_next = SCR_WR;

      SCR_WR: begin
        if (w_reg == LAST_COPY_W) begin
          // Copy done: blank the freshly exposed bottom row.
          state_next = CLR;
          w_next     = LAST_ROW_W0;
          end_next   = LAST_W_ALL;
        end else begin
          state_next = SCR_RD;
          w_next     = w_reg + 11'd1;
        end
      end

      CLR: begin
        if (w_reg == end_reg) state_next = IDLE;
        else                  w_next     = w_reg + 11'd1;
      end

      default: state_next = IDLE;
    endcase

    case (state_next)
      PUT: begin
        enb_next   = 1'b1;
        web_next   = 8'h01 << col_reg[2:0];
        addrb_next = {1'b0, row_reg, col_reg[6:3]};
        dinb_next  = {8{tty_data}};
      end
      SCR_RD: begin
        enb_next   = 1'b1;
        addrb_next = w_next + ROW_STRIDE;
      end
      SCR_WR: begin
        // doutb carries the word read one row below, issued in SCR_RD.
        enb_next   = 1'b1;
        web_next   = 8'hFF;
        addrb_next = w_next;
        dinb_next  = doutb;
      end
      CLR: begin
        enb_next   = 1'b1;
        web_next   = 8'hFF;
        addrb_next = w_next;
        dinb_next  = SPACE_WORD;
      end
      default: ;
    endcase
  end

  assign ready_next = (state_next == IDLE) && !init_pend_next;
  assign busy_next  = (state_next == SCR_RD) || (state_next == SCR_WT) ||
                      (state_next == SCR_WR) || (state_next == CLR);

  // State, cursor, counters and all outputs; reset abandons any scroll/clear.
  always_ff @(posedge clk_data) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      row_reg         <= 6'd0;
      col_reg         <= 7'd0;
      w_reg           <= 11'd0;
      end_reg         <= 11'd0;
      scroll_pend_reg <= 1'b0;
      init_pend_reg   <= 1'b1;
      ready_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      enb_reg         <= 1'b0;
      web_reg         <= 8'h00;
      addrb_reg       <= 11'd0;
      dinb_reg        <= 64'd0;
    end else begin
      state_reg       <= state_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      w_reg           <= w_next;
      end_reg         <= end_next;
      scroll_pend_reg <= scroll_pend_next;
      init_pend_reg   <= init_pend_next;
      ready_reg       <= ready_next;
      busy_reg        <= busy_next;
      enb_reg         <= enb_next;
      web_reg         <= web_next;
      addrb_reg       <= addrb_next;
      dinb_reg        <= dinb_next;
    end
  end

  assign tty_ready = ready_reg;
  assign busy      = busy_reg;
  assign enb       = enb_reg;
  assign web       = web_reg;
  assign addrb     = addrb_reg;
  assign dinb      = dinb_reg;
  assign cur_row   = row_reg;
  assign cur_col   = col_reg;

endmodule

// File: tb/tb_tty_fb_writer.sv
// Bench for tty_fb_writer: a character-grid screen model predicts every
// port-B transaction into a queue; a monitor pops and compares each one.
module tb_tty_fb_writer;
  import tty_fb_pkg::*;

  localparam int COLS  = 128;
  localparam int ROWS  = 4;
  localparam int WORDS = ROWS * 16;

  logic        clk_data = 1'b0;
  logic        rst_ni   = 1'b0;
  logic [7:0]  tty_data = 8'h00;
  logic        tty_valid = 1'b0;
  logic        tty_ready;
  logic        enb;
  logic [7:0]  web;
  logic [10:0] addrb;
  logic [63:0] dinb;
  logic [63:0] doutb;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  always #5 clk_data = ~clk_data;

  tty_fb_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1)) dut (
    .clk_data (clk_data),
    .rst_ni   (rst_ni),
    .tty_data (tty_data),
    .tty_valid(tty_valid),
    .tty_ready(tty_ready),
    .enb      (enb),
    .web      (web),
    .addrb    (addrb),
    .dinb     (dinb),
    .doutb    (doutb),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  // Behavioural dualmem port B: byte-lane writes, registered read.
  logic [63:0] ram [0:2047];
  always @(posedge clk_data) begin
    if (enb) begin
      for (int k = 0; k < 8; k++)
        if (web[k]) ram[addrb][8*k +: 8] <= dinb[8*k +: 8];
      doutb <= ram[addrb];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  web;
    logic [63:0] data;
  } op_t;
  op_t exp_q[$];

  // Screen model: character grid plus cursor.
  logic [7:0] scr [ROWS][128];
  int mr = 0;
  int mc = 0;

  function automatic logic [63:0] word_of(input int r, input int wi);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = scr[r][wi*8 + k];
    return w;
  endfunction

  task automatic push_op(input int addr, input logic [7:0] w, input logic [63:0] d);
    op_t o;
    o.addr = 11'(addr);
    o.web  = w;
    o.data = d;
    exp_q.push_back(o);
  endtask

  task automatic clear_rows(input int r0, input int n);
    for (int r = r0; r < r0 + n; r++) begin
      for (int c = 0; c < 128; c++) scr[r][c] = SPACE;
      for (int wi = 0; wi < 16; wi++) push_op(r*16 + wi, 8'hFF, {8{SPACE}});
    end
  endtask

  task automatic scroll_up();
    for (int w = 0; w < (ROWS-1)*16; w++) begin
      push_op(w + 16, 8'h00, 64'd0);
      push_op(w, 8'hFF, word_of(w/16 + 1, w%16));
    end
    for (int r = 0; r < ROWS-1; r++)
      for (int c = 0; c < 128; c++) scr[r][c] = scr[r+1][c];
    clear_rows(ROWS-1, 1);
  endtask

  task automatic model_byte(input logic [7:0] b, output int exp_busy, output int exp_stall);
    exp_busy  = 0;
    exp_stall = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_op(mr*16 + mc/8, 8'(1 << (mc%8)), {8{b}});
      scr[mr][mc] = b;
      exp_stall = 1;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        if (mr < ROWS-1) mr++;
        else begin scroll_up(); exp_busy = (ROWS-1)*48 + 16; end
      end
    end else if (b == CR) begin
      mc = 0;
    end else if (b == LF) begin
      if (mr < ROWS-1) mr++;
      else begin scroll_up(); exp_busy = (ROWS-1)*48 + 16; end
    end else if (b == BS) begin
      if (mc > 0) mc--;
    end else if (b == FF) begin
      clear_rows(0, ROWS);
      mr = 0;
      mc = 0;
      exp_busy = WORDS;
    end
    exp_stall += exp_busy;
  endtask

  // Monitor: every enabled port-B cycle must match the next predicted op.
  always @(negedge clk_data) begin
    op_t o;
    if (enb === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_op: got addr %0h web %0h, expected none", addrb, web);
      end else begin
        o = exp_q.pop_front();
        check("op_addr", 64'(addrb), 64'(o.addr));
        check("op_web", 64'(web), 64'(o.web));
        if (o.web != 8'h00) check("op_data", dinb, o.data);
      end
    end
  end

  // Counts negedges until tty_ready returns; bounded.
  task automatic wait_ready(output int stall, output int bcnt);
    bit done;
    stall = 0;
    bcnt  = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk_data);
      if (tty_ready === 1'b1) done = 1;
      else begin
        stall++;
        if (busy === 1'b1) bcnt++;
        if (stall > 6000) begin
          total++;
          bad++;
          $display("FAIL ready_timeout: got ready %0b after %0d cycles, expected 1", tty_ready, stall);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wait_done);
    int eb, es, stall, bcnt, guard;
    model_byte(b, eb, es);
    guard = 0;
    while (tty_ready !== 1'b1 && guard < 6000) begin
      @(negedge clk_data);
      guard++;
    end
    if (guard >= 6000) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready %0b, expected 1", tty_ready);
    end
    tty_data  = b;
    tty_valid = 1'b1;
    @(posedge clk_data);
    #1 tty_valid = 1'b0;
    if (wait_done) begin
      wait_ready(stall, bcnt);
      check("stall_cycles", 64'(stall), 64'(es));
      check("busy_cycles", 64'(bcnt), 64'(eb));
      check("cur_row", 64'(cur_row), 64'(mr));
      check("cur_col", 64'(cur_col), 64'(mc));
      $display("byte %02h -> cursor (%0d,%0d) busy %0d", b, cur_row, cur_col, bcnt);
    end
  endtask

  task automatic do_reset();
    int stall, bcnt;
    @(negedge clk_data);
    #1;
    rst_ni    = 1'b0;
    tty_valid = 1'b0;
    exp_q.delete();
    @(posedge clk_data);
    #1;
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_web", 64'(web), 64'd0);
    check("rst_addrb", 64'(addrb), 64'd0);
    check("rst_dinb", dinb, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(tty_ready), 64'd0);
    check("rst_row", 64'(cur_row), 64'd0);
    check("rst_col", 64'(cur_col), 64'd0);
    @(negedge clk_data);
    mr = 0;
    mc = 0;
    clear_rows(0, ROWS);
    rst_ni = 1'b1;
    wait_ready(stall, bcnt);
    check("reset_clear_cycles", 64'(bcnt), 64'(WORDS));
    $display("reset -> clear busy %0d", bcnt);
  endtask

  task automatic mem_check();
    for (int w = 0; w < WORDS; w++) check("ram_word", ram[w], word_of(w/16, w%16));
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 70)      b = 8'($urandom_range(32, 126));
    else if (r < 78) b = CR;
    else if (r < 88) b = LF;
    else if (r < 93) b = BS;
    else if (r < 95) b = FF;
    else begin
      b = 8'($urandom_range(0, 255));
      while ((b >= 8'h20 && b <= 8'h7E) || b == CR || b == LF || b == BS || b == FF)
        b = 8'($urandom_range(0, 255));
    end
    return b;
  endfunction

  initial begin
    // Power-up reset and full clear.
    do_reset();
    mem_check();
    // Single printable at home.
    send_byte(8'h41, 1);
    // Move to (3,9), write, then BS and CR.
    send_byte(CR, 1);
    repeat (3) send_byte(LF, 1);
    for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + i), 1);
    send_byte(8'h5A, 1);
    send_byte(BS, 1);
    send_byte(CR, 1);
    // BS at column 0 is a no-op.
    send_byte(BS, 1);
    // LF on the last row scrolls.
    send_byte(LF, 1);
    // Fill the last row and wrap off column 127.
    for (int i = 0; i < 127; i++) send_byte(8'($urandom_range(32, 126)), 1);
    send_byte(8'h41, 1);
    // Random traffic.
    for (int i = 0; i < 300; i++) send_byte(rand_byte(), 1);
    mem_check();
    // Reset in the middle of a scroll.
    send_byte(CR, 1);
    repeat (ROWS) send_byte(LF, 1);
    send_byte(LF, 0);
    repeat (40) @(negedge clk_data);
    check("mid_scroll_busy", 64'(busy), 64'd1);
    do_reset();
    mem_check();
    send_byte(8'h42, 1);
    repeat (4) @(negedge clk_data);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

endmodule
